bip_data_memory: RTL and testbench

BIP_DATA_MEMORY -- requirements
Module: bip_data_memory

---
 rtl/bip_pkg.sv | 10 +
 rtl/bip_sp_ram.sv | 24 ++
 rtl/bip_data_memory.sv | 104 ++++++++++
 tb/tb_bip_data_memory.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/bip_pkg.sv
// Shared defaults and state encoding for the BIP data memory.
package bip_pkg;
  localparam int BIP_DATA_W = 16;
  localparam int BIP_ADDR_W = 11;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } mem_state_e;
endpackage

// File: rtl/bip_sp_ram.sv
// Single-port word array: synchronous write, registered read-first read.
module bip_sp_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 11,
  parameter int DEPTH  = 2048
) (
  input  logic              Clock,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Read and write share the edge; the non-blocking read returns the old word.
  always_ff @(posedge Clock) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/bip_data_memory.sv
// CPU data memory: zero-fill after reset, 1-cycle registered loads,
// out-of-range access flagging.
module bip_data_memory
  import bip_pkg::*;
#(
  parameter int DATA_W         = BIP_DATA_W,
  parameter int ADDR_W         = BIP_ADDR_W,
  parameter int DEPTH          = 1 << BIP_ADDR_W,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Rd,
  input  logic              Wr,
  input  logic [ADDR_W-1:0] DataAddr,
  input  logic [DATA_W-1:0] In_Data,
  output logic [DATA_W-1:0] Out_Data,
  output logic              Valid,
  output logic              AddrErr,
  output logic              Busy
);
  localparam int CNT_W = (DEPTH == (1 << ADDR_W)) ? ADDR_W + 1 : ADDR_W;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);
  localparam mem_state_e        RESET_ST = (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;

  mem_state_e        state_q, state_d;
  logic [CNT_W-1:0]  clr_cnt_q, clr_cnt_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic              zero_q, zero_d;

  logic              in_range;
  logic              ram_we, ram_re;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  always_comb begin
    in_range  = {1'b0, DataAddr} < DEPTH_X;
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    zero_d    = zero_q;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_addr  = DataAddr;
    ram_wdata = In_Data;
    unique case (state_q)
      CLEAR: begin
        ram_we    = 1'b1;
        ram_addr  = clr_cnt_q[ADDR_W-1:0];
        ram_wdata = '0;
        // Counter parks on the last address instead of wrapping.
        if (clr_cnt_q == CNT_LAST) state_d = IDLE;
        else                       clr_cnt_d = clr_cnt_q + 1'b1;
      end
      IDLE: begin
        ram_we  = Wr && in_range;
        ram_re  = Rd && in_range;
        valid_d = Rd;
        err_d   = (Rd || Wr) && !in_range;
        // An out-of-range load must read as zero until the next good load.
        if (Rd) zero_d = !in_range;
      end
      default: state_d = RESET_ST;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= RESET_ST;
      clr_cnt_q <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      zero_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      zero_q    <= zero_d;
    end
  end

  bip_sp_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .Clock  (Clock),
    .we_i   (ram_we),
    .re_i   (ram_re),
    .addr_i (ram_addr),
    .wdata_i(ram_wdata),
    .rdata_o(ram_rdata)
  );

  assign Out_Data = zero_q ? '0 : ram_rdata;
  assign Valid    = valid_q;
  assign AddrErr  = err_q;
  assign Busy     = (state_q == CLEAR);
endmodule

// File: tb/tb_bip_data_memory.sv
// Scoreboard bench: two small instances (clearing / non-clearing) driven with directed accesses.
module tb_bip_data_memory;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: DEPTH=4, ADDR_W=3, zero-fill on reset
  logic        Reset_a, Rd_a, Wr_a, Valid_a, AddrErr_a, Busy_a;
  logic [2:0]  Addr_a;
  logic [15:0] Din_a, Dout_a;
  // Instance B: DEPTH=4, ADDR_W=2, contents kept across reset
  logic        Reset_b, Rd_b, Wr_b, Valid_b, AddrErr_b, Busy_b;
  logic [1:0]  Addr_b;
  logic [15:0] Din_b, Dout_b;

  bip_data_memory #(.DATA_W(16), .ADDR_W(3), .DEPTH(4), .CLEAR_ON_RESET(1)) dut_a (
    .Clock(clk), .Reset(Reset_a), .Rd(Rd_a), .Wr(Wr_a), .DataAddr(Addr_a),
    .In_Data(Din_a), .Out_Data(Dout_a), .Valid(Valid_a), .AddrErr(AddrErr_a), .Busy(Busy_a));

  bip_data_memory #(.DATA_W(16), .ADDR_W(2), .DEPTH(4), .CLEAR_ON_RESET(0)) dut_b (
    .Clock(clk), .Reset(Reset_b), .Rd(Rd_b), .Wr(Wr_b), .DataAddr(Addr_b),
    .In_Data(Din_b), .Out_Data(Dout_b), .Valid(Valid_b), .AddrErr(AddrErr_b), .Busy(Busy_b));

  typedef struct packed {
    logic        vld;
    logic        err;
    logic [15:0] data;
  } exp_t;

  exp_t        qa[$];
  exp_t        qb[$];
  logic [15:0] model [2][4];
  int          vectors = 0;
  int          miscompares = 0;
  bit          busy_b_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
    end
  endtask

  // Outputs settle after the rising edge; sample and drive around the falling edge.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic mon(input string name, input logic v, input logic e, input logic [15:0] d,
                     inout exp_t q[$]);
    exp_t x;
    if (q.size() == 0) begin
      check({name, " unexpected output"}, {14'd0, v, e, d}, 32'd0);
    end else begin
      x = q.pop_front();
      check({name, " vld/err"}, {30'd0, v, e}, {30'd0, x.vld, x.err});
      if (x.vld) check({name, " data"}, {16'd0, d}, {16'd0, x.data});
    end
  endtask

  always @(negedge clk) begin
    if (qa.size() > 0 || Valid_a || AddrErr_a) mon("A", Valid_a, AddrErr_a, Dout_a, qa);
    if (qb.size() > 0 || Valid_b || AddrErr_b) mon("B", Valid_b, AddrErr_b, Dout_b, qb);
    if (Busy_b) busy_b_seen = 1'b1;
  end

  task automatic acc(input int sel, input logic rd, input logic wr, input int addr,
                     input logic [15:0] data);
    exp_t e;
    bit   inr;
    inr = (addr < 4);
    if (sel == 0) begin
      Rd_a = rd; Wr_a = wr; Addr_a = 3'(addr); Din_a = data;
    end else begin
      Rd_b = rd; Wr_b = wr; Addr_b = 2'(addr); Din_b = data;
    end
    if (rd) begin
      e.vld = 1'b1; e.err = !inr; e.data = inr ? model[sel][addr] : 16'h0000;
    end else begin
      e.vld = 1'b0; e.err = wr && !inr; e.data = 16'h0000;
    end
    if (e.vld || e.err) begin
      if (sel == 0) qa.push_back(e);
      else          qb.push_back(e);
    end
    if (wr && inr) model[sel][addr] = data;
    step();
    if (sel == 0) begin Rd_a = 1'b0; Wr_a = 1'b0; end
    else          begin Rd_b = 1'b0; Wr_b = 1'b0; end
  endtask

  task automatic count_busy(input string name);
    int n;
    n = 0;
    while (Busy_a && n < 20) begin
      n++;
      step();
    end
    check(name, 32'(n), 32'd4);
  endtask

  initial begin
    Reset_a = 1'b1; Rd_a = 1'b0; Wr_a = 1'b0; Addr_a = '0; Din_a = '0;
    Reset_b = 1'b1; Rd_b = 1'b0; Wr_b = 1'b0; Addr_b = '0; Din_b = '0;
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 4; i++) model[s][i] = 16'h0000;

    step();
    check("A reset Out_Data", {16'd0, Dout_a}, 32'd0);
    check("A reset Valid/AddrErr", {30'd0, Valid_a, AddrErr_a}, 32'd0);
    check("A reset Busy", {31'd0, Busy_a}, 32'd1);
    check("B reset Busy", {31'd0, Busy_b}, 32'd0);
    Reset_a = 1'b0;
    Reset_b = 1'b0;
    count_busy("A clear length");

    for (int i = 0; i < 4; i++) acc(0, 1'b1, 1'b0, i, 16'h0);

    acc(0, 1'b0, 1'b1, 1, 16'h00A5);
    acc(0, 1'b1, 1'b0, 1, 16'h0);
    step();
    check("A hold Out_Data", {16'd0, Dout_a}, 32'h00A5);

    acc(0, 1'b0, 1'b1, 2, 16'h1234);
    acc(0, 1'b1, 1'b1, 2, 16'hBEEF);
    acc(0, 1'b1, 1'b0, 2, 16'h0);

    acc(0, 1'b0, 1'b1, 5, 16'hFFFF);
    acc(0, 1'b1, 1'b0, 5, 16'h0);
    step();
    check("A hold zero after bad read", {16'd0, Dout_a}, 32'd0);
    for (int i = 0; i < 4; i++) acc(0, 1'b1, 1'b0, i, 16'h0);

    // Reset coinciding with a read must swallow the Valid pulse
    Rd_a = 1'b1; Addr_a = 3'd0; Reset_a = 1'b1;
    step();
    check("A reset mid-read Out_Data", {16'd0, Dout_a}, 32'd0);
    Rd_a = 1'b0; Reset_a = 1'b0;
    step();
    step();
    Reset_a = 1'b1;
    step();
    Reset_a = 1'b0;
    Rd_a = 1'b1; Wr_a = 1'b1; Addr_a = 3'd1; Din_a = 16'hDEAD;
    count_busy("A restarted clear length");
    Rd_a = 1'b0; Wr_a = 1'b0;
    for (int i = 0; i < 4; i++) model[0][i] = 16'h0000;
    for (int i = 0; i < 4; i++) acc(0, 1'b1, 1'b0, i, 16'h0);

    acc(1, 1'b0, 1'b1, 3, 16'h0007);
    Reset_b = 1'b1;
    step();
    Reset_b = 1'b0;
    acc(1, 1'b1, 1'b0, 3, 16'h0);
    step();
    step();

    check("A scoreboard drained", 32'(qa.size()), 32'd0);
    check("B scoreboard drained", 32'(qb.size()), 32'd0);
    check("B Busy ever seen", {31'd0, busy_b_seen}, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
